// File: rtl/score_bcd_display.sv
// Binary score to 3-digit BCD via sequential double-dabble, driving three active-low 7-segment digits.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module score_bcd_display #(
  parameter int SCORE_BIT = 8
) (
  input  logic                 clock_25,
  input  logic                 reset,
  input  logic [SCORE_BIT-1:0] score,
  output logic [11:0]          bcd,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam int DW = 12 + SCORE_BIT;
  localparam logic [3:0] LAST_SHIFT = 4'(SCORE_BIT - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] RST_HIGH_DIGIT = SEG_BLANK;
`else
  localparam logic [6:0] RST_HIGH_DIGIT = SEG_ZERO;
`endif

  state_t                 state_reg;
  logic [SCORE_BIT-1:0]   score_latched_reg;
  logic [DW-1:0]          dd_reg;        // {bcd scratch, binary shift register}
  logic [3:0]             count_reg;
  logic [11:0]            scratch;
  logic [11:0]            adj;
  logic [6:0]             hex0_next;
  logic [6:0]             hex1_next;
  logic [6:0]             hex2_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign scratch = dd_reg[DW-1 -: 12];

  // Add-3 correction on every BCD nibble ahead of the shift in the same cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch[gi*4 +: 4] >= 4'd5) ?
                              scratch[gi*4 +: 4] + 4'd3 : scratch[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    hex0_next = seg7(scratch[3:0]);
    hex1_next = seg7(scratch[7:4]);
    hex2_next = seg7(scratch[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
    if (scratch[11:8] == 4'd0) begin
      hex2_next = SEG_BLANK;
      if (scratch[7:4] == 4'd0) hex1_next = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_reg         <= IDLE;
      score_latched_reg <= '0;
      dd_reg            <= '0;
      count_reg         <= '0;
      bcd               <= 12'h000;
      hex0              <= SEG_ZERO;
      hex1              <= RST_HIGH_DIGIT;
      hex2              <= RST_HIGH_DIGIT;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (score != score_latched_reg) begin
            score_latched_reg <= score;
            dd_reg            <= {12'h000, score};
            count_reg         <= '0;
            busy              <= 1'b1;
            state_reg         <= SHIFT;
          end
        end
        SHIFT: begin
          dd_reg    <= {adj, dd_reg[SCORE_BIT-1:0]} << 1;
          count_reg <= count_reg + 4'd1;
          if (count_reg == LAST_SHIFT) state_reg <= LOAD;
        end
        LOAD: begin
          bcd       <= scratch;
          hex0      <= hex0_next;
          hex1      <= hex1_next;
          hex2      <= hex2_next;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Randomized self-checking bench for score_bcd_display against an arithmetic decimal-digit model.
module tb_score_bcd_display;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] score;
  logic [11:0] bcd;
  logic [6:0] hex0, hex1, hex2;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int shown   = 0;
  logic [6:0] seg_tab [10];

  score_bcd_display #(.SCORE_BIT(8)) dut (
    .clock_25(clk), .reset(rst), .score(score), .bcd(bcd),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // digit: 0 units, 1 tens, 2 hundreds
  function automatic logic [6:0] model_hex(input int v, input int digit);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (digit == 0) return seg_tab[u];
`ifdef LEADING_ZERO_BLANK_EN
    if (digit == 1) return (h == 0 && t == 0) ? 7'h7f : seg_tab[t];
    return (h == 0) ? 7'h7f : seg_tab[h];
`else
    if (digit == 1) return seg_tab[t];
    return seg_tab[h];
`endif
  endfunction

  task automatic check_display(input string tag, input int v);
    check({tag, "_bcd"},  32'(bcd),  32'(model_bcd(v)));
    check({tag, "_hex0"}, 32'(hex0), 32'(model_hex(v, 0)));
    check({tag, "_hex1"}, 32'(hex1), 32'(model_hex(v, 1)));
    check({tag, "_hex2"}, 32'(hex2), 32'(model_hex(v, 2)));
  endtask

  // Edges until done rises (41 on timeout); flags any output change before it.
  task automatic wait_done(input logic [11:0] old_bcd, output int lat, output bit held_ok);
    lat = 41;
    held_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (bcd !== old_bcd) held_ok = 1'b0;
    end
  endtask

  task automatic convert(input int v, input string tag);
    int lat;
    bit held_ok;
    logic [11:0] old_bcd;
    old_bcd = model_bcd(shown);
    score = 8'(v);
    @(posedge clk); #1;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_done(old_bcd, lat, held_ok);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_held"}, 32'(held_ok), 32'd1);
    check_display(tag, v);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
    shown = v;
    $display("[TB] convert %0d: lat=%0d bcd=%03h hex=%02h/%02h/%02h", v, lat, bcd, hex2, hex1, hex0);
  endtask

  task automatic count_dones(input int edges, output int n, output logic [11:0] first_bcd,
                             output logic [11:0] last_bcd);
    n = 0;
    first_bcd = '0;
    last_bcd = '0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (n == 0) first_bcd = bcd;
        last_bcd = bcd;
        n++;
      end
    end
  endtask

  initial begin
    int v, a, b, c, n, lat;
    bit held_ok;
    logic [11:0] fb, lb;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    rst = 1'b1;
    score = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_display("reset", 0);
    $display("[TB] reset: bcd=%03h hex=%02h/%02h/%02h", bcd, hex2, hex1, hex0);
    rst = 1'b0;

    convert(42, "d42");
    convert(255, "d255");
    convert(7, "d7");
    convert(0, "d0");
    convert(100, "d100");

    count_dones(15, n, fb, lb);
    check("hold_no_done", 32'(n), 32'd0);
    $display("[TB] hold: dones=%0d", n);

    for (int k = 0; k < 20; k++) begin
      do v = $urandom_range(0, 255); while (v == shown);
      convert(v, "rand");
    end

    // Score changes mid-conversion: both values eventually shown.
    do a = $urandom_range(0, 255); while (a == shown);
    do b = $urandom_range(0, 255); while (b == a);
    score = 8'(a);
    repeat (3) @(posedge clk);
    #1;
    score = 8'(b);
    count_dones(40, n, fb, lb);
    check("chg_ndone", 32'(n), 32'd2);
    check("chg_first", 32'(fb), 32'(model_bcd(a)));
    check("chg_last", 32'(lb), 32'(model_bcd(b)));
    check_display("chg_final", b);
    shown = b;
    $display("[TB] change %0d->%0d: dones=%0d first=%03h last=%03h", a, b, n, fb, lb);

    // Score bounces away and back while busy: single conversion.
    do a = $urandom_range(0, 255); while (a == shown);
    do c = $urandom_range(0, 255); while (c == a);
    score = 8'(a);
    repeat (2) @(posedge clk);
    #1;
    score = 8'(c);
    repeat (2) @(posedge clk);
    #1;
    score = 8'(a);
    count_dones(30, n, fb, lb);
    check("bounce_ndone", 32'(n), 32'd1);
    check("bounce_bcd", 32'(lb), 32'(model_bcd(a)));
    shown = a;
    $display("[TB] bounce %0d->%0d->%0d: dones=%0d bcd=%03h", a, c, a, n, lb);

    // Reset sampled at the 4th shift edge aborts, then 200 converts after release.
    if (shown == 200) convert(1, "pre_rst");
    score = 8'd200;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check_display("rst_mid", 0);
    rst = 1'b0;
    shown = 0;
    wait_done(model_bcd(0), lat, held_ok);
    check("rst_post_lat", 32'(lat), 32'd10);
    check_display("rst_post", 200);
    shown = 200;
    $display("[TB] reset mid-conversion: lat=%0d bcd=%03h", lat, bcd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
